// File: rtl/row_sync_arbiter.sv
// Row-level synchroniser shared by the cores of one row.
// Provides a registered round-robin grant of the shared row URAM with fill
// accounting, a drain handshake towards the VGA drain logic, a per-owner
// watchdog and a hardware barrier. The barrier runs independently of the
// arbiter.
//
// Handshake: i_core_req / o_core_grant is a level handshake. A core raises
// i_core_req and holds it. o_core_grant[i] rises one cycle after the core
// wins arbitration and stays high while the core keeps i_core_req high.
// The owner releases the URAM by dropping i_core_req, and the grant falls on
// the next cycle. Requests from other cores wait until the arbiter is back
// in IDLE. A grant held for GRANT_TIMEOUT cycles is revoked by the watchdog.
module row_sync_arbiter #(
  parameter int NUM_CORES      = 8,
  parameter int FILL_THRESHOLD = 4,
  parameter int GRANT_TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CORES-1:0] i_core_req,
  output logic [NUM_CORES-1:0] o_core_grant,
  output logic                 o_uram_full,
  input  logic                 i_uram_emptied,
  input  logic [NUM_CORES-1:0] i_core_active,
  input  logic [NUM_CORES-1:0] i_barrier_arrive,
  output logic                 o_barrier_release,
  output logic [NUM_CORES-1:0] o_timeout_err,
  output logic [1:0]           o_dbg_state
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int FW = $clog2(FILL_THRESHOLD + 1);
  localparam int WW = $clog2(GRANT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] grant, grant_nxt;
  logic [NUM_CORES-1:0] err, err_nxt;
  logic [IW-1:0]        owner, owner_nxt;
  logic [IW-1:0]        rr_ptr, rr_nxt;
  logic [FW-1:0]        fill, fill_nxt;
  logic [WW-1:0]        wdog, wdog_nxt;

  logic [IW-1:0]        winner;
  logic                 found;
  int                   idx;
  logic                 owner_req;

  logic [NUM_CORES-1:0] arrive_flags;
  logic [NUM_CORES-1:0] arrive_all;
  logic                 barrier_hit;
  logic                 release_q;

  // Round-robin search: the first requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && i_core_req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign owner_req = i_core_req[owner];

  // Next-state and next-register logic for the arbiter FSM.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    fill_nxt  = fill;
    wdog_nxt  = wdog;
    err_nxt   = err;
    case (state)
      ST_IDLE: begin
        // A full URAM takes precedence over any pending request.
        if (fill == FW'(FILL_THRESHOLD)) begin
          state_nxt = ST_DRAIN;
        end else if (found) begin
          state_nxt = ST_GRANT;
          grant_nxt = {{(NUM_CORES-1){1'b0}}, 1'b1} << winner;
          owner_nxt = winner;
          rr_nxt    = (winner == IW'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
          wdog_nxt  = WW'(1);
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          fill_nxt  = fill + 1'b1;
        end else if (wdog == WW'(GRANT_TIMEOUT)) begin
          // Revoked grants are not counted as completed URAM fills.
          state_nxt      = ST_IDLE;
          grant_nxt      = '0;
          err_nxt[owner] = 1'b1;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_uram_emptied) begin
          state_nxt = ST_IDLE;
          fill_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Arbiter state registers; reset drops the grant asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      err    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      fill   <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      err    <= err_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      fill   <= fill_nxt;
      wdog   <= wdog_nxt;
    end
  end

  // Barrier completes when every active core has arrived, counting this cycle.
  assign arrive_all  = arrive_flags | i_barrier_arrive;
  assign barrier_hit = (i_core_active != '0) &&
                       ((arrive_all & i_core_active) == i_core_active);

  // Barrier flags accumulate arrivals and clear on the completing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arrive_flags <= '0;
      release_q    <= 1'b0;
    end else begin
      release_q    <= barrier_hit;
      arrive_flags <= barrier_hit ? '0 : arrive_all;
    end
  end

  assign o_core_grant      = grant;
  assign o_uram_full       = (state == ST_DRAIN);
  assign o_barrier_release = release_q;
  assign o_timeout_err     = err;
  assign o_dbg_state       = state;

endmodule
